// File: rtl/mdr_mem_ctrl.sv
// MAR/MDR registers and the single-outstanding memory read/write handshake FSM.
// Every access ends with a one-cycle DONE state; err marks an access that timed out.
module mdr_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Loads land on the same edge the access starts, so the strobe
        // cycle already presents the freshly loaded MAR/MDR.
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        if (mdr_in) mdr_d = bus_in;
        cnt_d = '0;
        if (mem_rd_req)      state_d = RD_WAIT;
        else if (mem_wr_req) state_d = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ready) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (state_q == RD_WAIT) mdr_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_re    = (state_q == RD_WAIT);
  assign mem_we    = (state_q == WR_WAIT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed bench for mdr_mem_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for the loads, read, write, timeout, collision and reset cases.
module tb_mdr_mem_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              clr;
  logic [DATA_W-1:0] bus_in;
  logic              mar_in, mdr_in, mem_rd_req, mem_wr_req;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_re, mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mdr_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mdr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: what kind of access is in flight and how many
  // strobe cycles it has used so far.
  typedef enum int {M_IDLE, M_READ, M_WRITE, M_FINISH} mode_t;
  mode_t             m_mode  = M_IDLE;
  int                m_used  = 0;
  logic [ADDR_W-1:0] m_mar   = '0;
  logic [DATA_W-1:0] m_mdr   = '0;
  bit                m_err   = 1'b0;

  initial forever begin
    @(posedge clk);
    if (clr) begin
      m_mode = M_IDLE; m_used = 0; m_mar = '0; m_mdr = '0; m_err = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (mar_in) m_mar = bus_in[ADDR_W-1:0];
      if (mdr_in) m_mdr = bus_in;
      m_used = 0;
      if (mem_rd_req)      m_mode = M_READ;
      else if (mem_wr_req) m_mode = M_WRITE;
    end else if (m_mode == M_FINISH) begin
      m_mode = M_IDLE;
    end else begin
      m_used = m_used + 1;
      if (mem_ready) begin
        if (m_mode == M_READ) m_mdr = mem_rdata;
        m_err  = 1'b0;
        m_mode = M_FINISH;
      end else if (m_used == TIMEOUT) begin
        m_err  = 1'b1;
        m_mode = M_FINISH;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    logic [4+ADDR_W+2*DATA_W:0] act, exp;
    @(negedge clk);
    if (chk_en) begin
      act = {mem_re, mem_we, busy, done, err, mem_addr, mem_wdata, mdr_out};
      exp = {m_mode == M_READ, m_mode == M_WRITE, m_mode != M_IDLE,
             m_mode == M_FINISH, (m_mode == M_FINISH) && m_err, m_mar, m_mdr, m_mdr};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs the wait phase from its first strobe cycle; ready_at=k raises mem_ready
  // in the k-th strobe cycle (0 = never). Returns in the done cycle.
  task automatic access(input int ready_at, input logic [DATA_W-1:0] rdata,
                        output int re_n, output int we_n, output bit got_done,
                        output bit got_err, output logic [ADDR_W-1:0] a_seen,
                        output logic [DATA_W-1:0] w_seen);
    int k = 0;
    re_n = 0; we_n = 0; got_done = 1'b0; got_err = 1'b0; a_seen = '0; w_seen = '0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
        break;
      end
      if (mem_re || mem_we) begin
        k++;
        if (mem_re) re_n++;
        if (mem_we) we_n++;
        a_seen = mem_addr;
        w_seen = mem_wdata;
      end
      mem_ready = (mem_re || mem_we) && (k == ready_at);
      mem_rdata = rdata;
      step();
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int re_n, we_n;
    bit got_done, got_err;
    logic [ADDR_W-1:0] a_seen;
    logic [DATA_W-1:0] w_seen;

    clr = 1'b1; bus_in = '0; mar_in = 0; mdr_in = 0; mem_rd_req = 0; mem_wr_req = 0;
    mem_rdata = '0; mem_ready = 0;
    step(); step();
    clr = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Bus loads; upper bus bits are dropped on the MAR load.
    bus_in = 32'hFFFF_FFFF; mem_ready = 1'b1; step();  // stray ready in IDLE is ignored
    mem_ready = 1'b0;
    bus_in = 32'h0000_01A5; mar_in = 1; step();
    mar_in = 0; bus_in = 32'hDEAD_BEEF; mdr_in = 1; step();
    mdr_in = 0;
    chk("load_mar", 32'(mem_addr), 32'h0000_01A5);
    chk("load_mdr", mdr_out, 32'hDEAD_BEEF);
    bus_in = 32'hABCD_EE10; mar_in = 1; step();
    mar_in = 0;
    chk("load_mar_trunc", 32'(mem_addr), 32'h0000_0010);

    // Read with ready in the third wait cycle.
    mem_rd_req = 1; step();
    mem_rd_req = 0;
    access(3, 32'h1234_5678, re_n, we_n, got_done, got_err, a_seen, w_seen);
    chk("rd_re_cycles", 32'(re_n), 32'd3);
    chk("rd_done", 32'(got_done), 32'd1);
    chk("rd_err", 32'(got_err), 32'd0);
    chk("rd_mdr", mdr_out, 32'h1234_5678);
    chk("rd_addr", 32'(a_seen), 32'h0000_0010);
    step();
    chk("rd_idle_after", 32'(busy), 32'd0);

    // Write, zero wait, MAR load in the same cycle as the request.
    bus_in = 32'hCAFE_F00D; mdr_in = 1; step();
    mdr_in = 0; bus_in = 32'h0000_01FF; mar_in = 1; mem_wr_req = 1; step();
    mar_in = 0; mem_wr_req = 0;
    access(1, 32'h0, re_n, we_n, got_done, got_err, a_seen, w_seen);
    chk("wr_we_cycles", 32'(we_n), 32'd1);
    chk("wr_re_cycles", 32'(re_n), 32'd0);
    chk("wr_addr", 32'(a_seen), 32'h0000_01FF);
    chk("wr_wdata", w_seen, 32'hCAFE_F00D);
    chk("wr_done", 32'(got_done), 32'd1);
    chk("wr_err", 32'(got_err), 32'd0);
    step();

    // Timeout: ready never comes, MDR must survive.
    mem_rd_req = 1; step();
    mem_rd_req = 0;
    access(0, 32'h5555_AAAA, re_n, we_n, got_done, got_err, a_seen, w_seen);
    chk("to_re_cycles", 32'(re_n), 32'd16);
    chk("to_done", 32'(got_done), 32'd1);
    chk("to_err", 32'(got_err), 32'd1);
    chk("to_mdr_kept", mdr_out, 32'hCAFE_F00D);
    step();
    chk("to_err_cleared", 32'(err), 32'd0);

    // Read and write requested together: read wins.
    mem_rd_req = 1; mem_wr_req = 1; step();
    mem_rd_req = 0; mem_wr_req = 0;
    access(2, 32'hA5A5_0001, re_n, we_n, got_done, got_err, a_seen, w_seen);
    chk("coll_re_cycles", 32'(re_n), 32'd2);
    chk("coll_we_cycles", 32'(we_n), 32'd0);
    chk("coll_mdr", mdr_out, 32'hA5A5_0001);
    step();

    // Loads and requests presented while busy are dropped.
    mem_rd_req = 1; step();
    mem_rd_req = 0; mdr_in = 1; mar_in = 1; mem_wr_req = 1; bus_in = 32'hFFFF_FFFF;
    access(2, 32'h0BAD_F00D, re_n, we_n, got_done, got_err, a_seen, w_seen);
    mdr_in = 0; mar_in = 0; mem_wr_req = 0;
    chk("busy_we_cycles", 32'(we_n), 32'd0);
    chk("busy_mdr", mdr_out, 32'h0BAD_F00D);
    chk("busy_mar", 32'(mem_addr), 32'h0000_01FF);
    step();
    step();
    chk("busy_no_extra", 32'(busy), 32'd0);

    // Reset in the middle of a read.
    mem_rd_req = 1; step();
    mem_rd_req = 0; step();
    chk("pre_reset_re", 32'(mem_re), 32'd1);
    clr = 1; step();
    clr = 0;
    chk("clr_re", 32'(mem_re), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_mdr", mdr_out, 32'd0);
    chk("clr_addr", 32'(mem_addr), 32'd0);
    step(); step();

    chk_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
